// File: rtl/conv1_ctrl.sv
// conv1_ctrl -- sequencer for the Convolution 1 layer.
//
// Steps two filter lanes over OUT_PIXELS output positions. For each position
// it clears the MAC accumulators, streams TAPS kernel-tap indices, waits out
// the MAC pipeline (MAC_LAT cycles), then issues one write per lane into the
// conv1 output memory (lane 0 at BASE0+pix, lane 1 at BASE1+pix).
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle pulse, begins a layer run when idle
//   mem_ready  in   output memory accepts writes this cycle
//   busy       out  high from start acceptance until done
//   done       out  sticky completion flag, cleared by next accepted start
//   mac_clear  out  clear both lane accumulators
//   mac_en     out  accumulate the current tap
//   tap_idx    out  [4:0] kernel tap index
//   pix_idx    out  [9:0] current output position
//   wr_en      out  write strobe common to both lanes (state & mem_ready)
//   addr0      out  [9:0] lane 0 write address
//   addr1      out  [9:0] lane 1 write address
//   stall_cnt  out  [15:0] saturating count of stalled WRITE cycles
//                   (present only with CONV1_CTRL_STALL_CNT_EN defined)
//
// Optional feature macro: CONV1_CTRL_STALL_CNT_EN

module conv1_ctrl #(
    parameter int unsigned TAPS       = 25,
    parameter int unsigned OUT_PIXELS = 144,
    parameter int unsigned BASE0      = 0,
    parameter int unsigned BASE1      = 144,
    parameter int unsigned MAC_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        mac_clear,
    output logic        mac_en,
    output logic [4:0]  tap_idx,
    output logic [9:0]  pix_idx,
    output logic        wr_en,
    output logic [9:0]  addr0,
    output logic [9:0]  addr1
`ifdef CONV1_CTRL_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [4:0] TAP_LAST = 5'(TAPS - 1);
    localparam logic [9:0] PIX_LAST = 10'(OUT_PIXELS - 1);
    localparam logic [9:0] BASE0_A  = 10'(BASE0);
    localparam logic [9:0] BASE1_A  = 10'(BASE1);
    localparam int unsigned FLUSH_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(MAC_LAT - 1);

    // Address adds are 10-bit and must never wrap; tap index is 5-bit.
    if (TAPS < 1 || TAPS > 32 || OUT_PIXELS < 1 ||
        BASE0 + OUT_PIXELS - 1 > 1023 || BASE1 + OUT_PIXELS - 1 > 1023) begin : g_param_check
        $error("conv1_ctrl: parameters exceed 10-bit address or 5-bit tap range");
    end

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACC,
        FLUSH,
        WRITE,
        NEXT
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           tap_q, tap_d;
    logic [9:0]           pix_q, pix_d;
    logic [9:0]           addr0_q, addr0_d;
    logic [9:0]           addr1_q, addr1_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 mac_clear_q, mac_clear_d;
    logic                 mac_en_q, mac_en_d;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        pix_d   = pix_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        flush_d = flush_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    tap_d   = '0;
                    pix_d   = '0;
                    addr0_d = BASE0_A;
                    addr1_d = BASE1_A;
                    done_d  = 1'b0;
                end
            end
            CLEAR: begin
                state_d = ACC;
            end
            ACC: begin
                if (tap_q == TAP_LAST) begin
                    flush_d = '0;
                    state_d = (MAC_LAT == 0) ? WRITE : FLUSH;
                end else begin
                    tap_d = tap_q + 5'd1;
                end
            end
            FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = WRITE;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if (pix_q == PIX_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                // Index and addresses advance on leaving NEXT so the tap
                // index is already back at 0 when CLEAR is presented.
                state_d = CLEAR;
                tap_d   = '0;
                pix_d   = pix_q + 10'd1;
                addr0_d = addr0_q + 10'd1;
                addr1_d = addr1_q + 10'd1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered strobes are decoded from the next state so they line up
        // with the state they belong to.
        busy_d      = (state_d != IDLE);
        mac_clear_d = (state_d == CLEAR);
        mac_en_d    = (state_d == ACC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            pix_q       <= '0;
            addr0_q     <= BASE0_A;
            addr1_q     <= BASE1_A;
            flush_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            pix_q       <= pix_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            flush_q     <= flush_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mac_clear_q <= mac_clear_d;
            mac_en_q    <= mac_en_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mac_clear = mac_clear_q;
    assign mac_en    = mac_en_q;
    assign tap_idx   = tap_q;
    assign pix_idx   = pix_q;
    assign addr0     = addr0_q;
    assign addr1     = addr1_q;
    // Combinational so a stalled WRITE produces exactly one strobe when ready.
    assign wr_en     = (state_q == WRITE) && mem_ready;

`ifdef CONV1_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start) begin
            stall_cnt_d = '0;
        end else if (state_q == WRITE && !mem_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv1_ctrl.sv
// Testbench for conv1_ctrl: randomized start noise and write back-pressure,
// every cycle compared against a phase-based model of the layer schedule.
module tb_conv1_ctrl;

    localparam int TAPS       = 25;
    localparam int OUT_PIXELS = 144;
    localparam int BASE0      = 0;
    localparam int BASE1      = 144;
    localparam int MAC_LAT    = 2;
    // Phase offsets within one pixel: 0 clear, 1..TAPS accumulate,
    // then MAC_LAT flush cycles, then write phase, then next phase.
    localparam int W_PH       = TAPS + MAC_LAT + 1;
    localparam int CYC_RUN    = OUT_PIXELS * (W_PH + 2) - 1;
    localparam int BUDGET     = 6000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_ready;
    logic        busy, done, mac_clear, mac_en, wr_en;
    logic [4:0]  tap_idx;
    logic [9:0]  pix_idx, addr0, addr1;
`ifdef CONV1_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv1_ctrl #(
        .TAPS      (TAPS),
        .OUT_PIXELS(OUT_PIXELS),
        .BASE0     (BASE0),
        .BASE1     (BASE1),
        .MAC_LAT   (MAC_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem_ready(mem_ready),
        .busy     (busy),
        .done     (done),
        .mac_clear(mac_clear),
        .mac_en   (mac_en),
        .tap_idx  (tap_idx),
        .pix_idx  (pix_idx),
        .wr_en    (wr_en),
        .addr0    (addr0),
        .addr1    (addr1)
`ifdef CONV1_CTRL_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_run;
    bit m_done;
    int m_pix;
    int m_t;
    int m_idle_tap;
    int m_stall;

    // Write observation
    int wr_cnt;
    int first_a0, first_a1, last_a0, last_a1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run      = 1'b0;
        m_done     = 1'b0;
        m_pix      = 0;
        m_t        = 0;
        m_idle_tap = 0;
        m_stall    = 0;
    endtask

    function automatic logic [39:0] model_vec(input logic rdy);
        logic       mc, me, we;
        logic [4:0] tp;
        mc = m_run && (m_t == 0);
        me = m_run && (m_t >= 1) && (m_t <= TAPS);
        we = m_run && (m_t == W_PH) && rdy;
        if (!m_run)           tp = 5'(m_idle_tap);
        else if (m_t == 0)    tp = 5'd0;
        else if (m_t <= TAPS) tp = 5'(m_t - 1);
        else                  tp = 5'(TAPS - 1);
        return {m_run, m_done, mc, me, tp, 10'(m_pix), we, 10'(BASE0 + m_pix), 10'(BASE1 + m_pix)};
    endfunction

    task automatic model_step(input logic st, input logic rdy);
        if (!m_run) begin
            if (st) begin
                m_run   = 1'b1;
                m_done  = 1'b0;
                m_pix   = 0;
                m_t     = 0;
                m_stall = 0;
            end
        end else if (m_t < W_PH) begin
            m_t++;
        end else if (m_t == W_PH) begin
            if (rdy) begin
                if (m_pix == OUT_PIXELS - 1) begin
                    m_run      = 1'b0;
                    m_done     = 1'b1;
                    m_idle_tap = TAPS - 1;
                end else begin
                    m_t++;
                end
            end else if (m_stall < 65535) begin
                m_stall++;
            end
        end else begin
            m_pix++;
            m_t = 0;
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, compare
    // outputs, then advance the model across the rising edge.
    task automatic tick(input logic st, input logic rdy);
        logic [39:0] got_v;
        start     = st;
        mem_ready = rdy;
        #1;
        got_v = {busy, done, mac_clear, mac_en, tap_idx, pix_idx, wr_en, addr0, addr1};
        check("cycle", got_v, model_vec(rdy));
        check("excl", ($countones({mac_clear, mac_en, wr_en}) <= 1), 1'b1);
`ifdef CONV1_CTRL_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        if (wr_en) begin
            if (wr_cnt == 0) begin
                first_a0 = addr0;
                first_a1 = addr1;
            end
            last_a0 = addr0;
            last_a1 = addr1;
            wr_cnt++;
        end
        @(posedge clk);
        model_step(st, rdy);
        @(negedge clk);
    endtask

    // mode 0: always ready; 1: 7-cycle stall on pixel 5; 2: random ready;
    // 3: reset asserted during ACC of pixel 60.
    task automatic run_layer(input int mode);
        int   cnt;
        int   lat;
        int   stall_seen;
        int   stall_left;
        bit   aborted;
        bit   in_wr;
        logic st, rdy;
        wr_cnt     = 0;
        lat        = -1;
        stall_seen = 0;
        stall_left = 7;
        aborted    = 1'b0;
        cnt        = 0;

        tick(1'b1, 1'b1);
        check("start_acc", {busy, done}, 2'b10);

        while (lat < 0 && cnt < BUDGET && !aborted) begin
            in_wr = m_run && (m_t == W_PH);
            rdy   = 1'b1;
            if (mode == 1 && in_wr && m_pix == 5 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            if (mode == 2) rdy = 1'($urandom_range(0, 3) != 0);
            st = 1'($urandom_range(0, 15) == 0);
            if (in_wr && m_pix == OUT_PIXELS - 1) st = 1'b1;

            if (mode == 3 && m_run && m_pix == 60 && m_t == 10) begin
                start     = 1'b0;
                mem_ready = 1'b1;
                #2 reset = 1'b1;
                #1;
                check("abort_outs", {busy, done, mac_clear, mac_en, tap_idx, pix_idx, wr_en}, '0);
                check("abort_a0", addr0, BASE0);
                check("abort_a1", addr1, BASE1);
                model_reset();
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("abort_wr", wr_en, 1'b0);
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                if (in_wr && !rdy) stall_seen++;
                tick(st, rdy);
                cnt++;
                if (done) lat = cnt;
            end
        end

        if (!aborted) begin
            check("done_seen", (lat >= 0), 1'b1);
            check("latency", lat, CYC_RUN + stall_seen);
            check("wr_count", wr_cnt, OUT_PIXELS);
            check("first_a0", first_a0, BASE0);
            check("first_a1", first_a1, BASE1);
            check("last_a0", last_a0, BASE0 + OUT_PIXELS - 1);
            check("last_a1", last_a1, BASE1 + OUT_PIXELS - 1);
            check("end_flags", {busy, done}, 2'b01);
`ifdef CONV1_CTRL_STALL_CNT_EN
            check("stall_total", stall_cnt, stall_seen);
`endif
        end
    endtask

    initial begin
        start     = 1'b0;
        mem_ready = 1'b0;
        reset     = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        repeat (10) tick(1'b0, 1'($urandom_range(0, 1)));
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_addr0", addr0, BASE0);
        check("rst_addr1", addr1, BASE1);

        run_layer(0);
        run_layer(1);          // start in the cycle right after done
        repeat (5) tick(1'b0, 1'b1);
        run_layer(3);
        repeat (3) tick(1'b0, 1'b1);
        run_layer(0);          // rerun from pixel 0 after the abort
        run_layer(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
